// File: rtl/alu_test_pkg.sv
// Shared definitions for the bitwise ALU slice self-test engines.
package alu_test_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/nor_golden.sv
// Reference model for a NOR slice; swap for AND/OR/XOR variants per slice op.
module nor_golden #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);
  assign expected = ~(a | b);
endmodule

// File: rtl/nor_slice_exerciser.sv
// Exhaustive operand sweep for a NOR slice: drives every {a,b}, waits, samples n,
// and records error count, failing bit lanes and the first failing operand pair.
module nor_slice_exerciser
  import alu_test_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   n,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_bits,
  output logic [WIDTH-1:0]   first_a,
  output logic [WIDTH-1:0]   first_b,
  output logic               first_vld
);
  localparam int VW = 2 * WIDTH;
  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  // With no settle time every vector is sampled back to back.
  localparam state_t RUN_ST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t           state, state_nx;
  logic [VW-1:0]    vec;
  logic [CW-1:0]    settle_cnt;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] diff;
  logic             last_vec;

  assign a        = vec[VW-1:WIDTH];
  assign b        = vec[WIDTH-1:0];
  assign busy     = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done     = (state == ST_DONE);
  assign diff     = n ^ expected;
  assign last_vec = &vec;

  nor_golden #(.WIDTH(WIDTH)) u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = RUN_ST;
      ST_SETTLE:        if (settle_cnt == CW'(1)) state_nx = ST_SAMPLE;
      ST_SAMPLE:        state_nx = last_vec ? ST_DONE : RUN_ST;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_bits  <= '0;
      first_a    <= '0;
      first_b    <= '0;
      first_vld  <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec        <= '0;
            settle_cnt <= SETTLE_LD;
            err_count  <= '0;
            fail_bits  <= '0;
            first_a    <= '0;
            first_b    <= '0;
            first_vld  <= 1'b0;
            pass       <= 1'b0;
          end
        end
        ST_SETTLE: settle_cnt <= settle_cnt - CW'(1);
        ST_SAMPLE: begin
          if (diff != '0) begin
            err_count <= err_count + (VW+1)'(1);
            fail_bits <= fail_bits | diff;
            if (!first_vld) begin
              first_a   <= a;
              first_b   <= b;
              first_vld <= 1'b1;
            end
          end
          // pass must include the final vector's outcome, not just the running count.
          if (last_vec) begin
            pass <= (err_count == '0) && (diff == '0);
          end else begin
            vec        <= vec + VW'(1);
            settle_cnt <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nor_slice_exerciser.sv
// Directed bench: golden and stuck-at slice models around two exerciser instances.
module tb_nor_slice_exerciser;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, start0 = 1'b0;
  logic [W-1:0] a, b, n, a0, b0, n0;
  logic         busy, done, pass, first_vld;
  logic         busy0, done0, pass0, first_vld0;
  logic [2*W:0] err_count, err_count0;
  logic [W-1:0] fail_bits, first_a, first_b;
  logic [W-1:0] fail_bits0, first_a0, first_b0;
  logic [W-1:0] sa0 = '0, sa1 = '0;

  int nvec = 0;
  int nmis = 0;
  int cyc;

  always #5 clk = ~clk;

  // Slice under test: NOR with injectable stuck-at lanes.
  assign n  = (~(a | b) & ~sa0) | sa1;
  assign n0 = ~(a0 | b0);

  nor_slice_exerciser #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .n(n),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_bits(fail_bits), .first_a(first_a), .first_b(first_b),
    .first_vld(first_vld)
  );

  nor_slice_exerciser #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .n(n0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .fail_bits(fail_bits0), .first_a(first_a0), .first_b(first_b0),
    .first_vld(first_vld0)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start, then count busy cycles (sampled on negedge); optionally re-pulse start mid-sweep.
  task automatic run_sweep(input int repulse_at, output int ncyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 5000) begin
      ncyc++;
      if (ncyc == 10) chk("pass_low_while_busy", int'(pass), 0);
      start = (ncyc == repulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (ncyc >= 5000) chk("sweep_timeout", ncyc, 768);
  endtask

  task automatic chk_results(input string tag, input int ec, input int fb,
                             input int fa, input int fbv, input int fv, input int ps);
    chk({tag, "_done"},      int'(done), 1);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_err_count"}, int'(err_count), ec);
    chk({tag, "_fail_bits"}, int'(fail_bits), fb);
    chk({tag, "_first_vld"}, int'(first_vld), fv);
    if (fv != 0) begin
      chk({tag, "_first_a"}, int'(first_a), fa);
      chk({tag, "_first_b"}, int'(first_b), fbv);
    end
    chk({tag, "_pass"},      int'(pass), ps);
    chk({tag, "_ab_last"},   int'({a, b}), 255);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_ab", int'({a, b}), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_first_vld", int'(first_vld), 0);

    // 1: golden slice
    run_sweep(0, cyc);
    chk("golden_cycles", cyc, 768);
    chk_results("golden", 0, 0, 0, 0, 0, 1);

    // 2: n[2] stuck at 0
    sa0 = 4'b0100;
    run_sweep(0, cyc);
    chk("sa0_cycles", cyc, 768);
    chk_results("sa0_bit2", 64, 4, 0, 0, 1, 0);
    sa0 = '0;

    // 3: n[0] stuck at 1
    sa1 = 4'b0001;
    run_sweep(0, cyc);
    chk_results("sa1_bit0", 192, 1, 0, 1, 1, 0);

    // start in DONE clears results and restarts
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_busy", int'(busy), 1);
    chk("restart_done", int'(done), 0);
    chk("restart_err", int'(err_count), 0);
    chk("restart_fail_bits", int'(fail_bits), 0);
    chk("restart_first_vld", int'(first_vld), 0);
    chk("restart_ab", int'({a, b}), 0);
    cyc = 0;
    while (busy && cyc < 5000) begin cyc++; @(negedge clk); end
    chk("restart_cycles", cyc, 768);
    chk_results("restart", 192, 1, 0, 1, 1, 0);

    // 4: reset mid-sweep with errors accumulated
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_err_nonzero", int'(err_count != 0), 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ab", int'({a, b}), 0);
    chk("midrst_err", int'(err_count), 0);
    chk("midrst_first_vld", int'(first_vld), 0);
    sa1 = '0;
    run_sweep(0, cyc);
    chk("post_rst_cycles", cyc, 768);
    chk_results("post_rst", 0, 0, 0, 0, 0, 1);

    // 5: start re-pulsed while busy is ignored
    run_sweep(50, cyc);
    chk("repulse_cycles", cyc, 768);
    chk_results("repulse", 0, 0, 0, 0, 0, 1);

    // 6: SETTLE_CYCLES=0 instance
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 5000) begin
      cyc++;
      if (cyc == 2)  chk("s0_vec_c2", int'({a0, b0}), 1);
      if (cyc == 18) chk("s0_vec_c18", int'({a0, b0}), 17);
      if (cyc == 200) chk("s0_vec_c200", int'({a0, b0}), 199);
      @(negedge clk);
    end
    chk("s0_cycles", cyc, 256);
    chk("s0_done", int'(done0), 1);
    chk("s0_busy", int'(busy0), 0);
    chk("s0_pass", int'(pass0), 1);
    chk("s0_err", int'(err_count0), 0);
    chk("s0_fail_bits", int'(fail_bits0), 0);
    chk("s0_first_vld", int'(first_vld0), 0);
    chk("s0_ab_last", int'({a0, b0}), 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
